// File: rtl/nonce_sweeper_if.sv
// rtl/nonce_sweeper_if.sv - handshake bundle between nonce_sweeper and the sha256d hasher
interface nonce_sweeper_if;
  logic         h_start;
  logic         h_rq;
  logic [4:0]   h_addr;
  logic [31:0]  h_data;
  logic         h_rdy;
  logic [255:0] h_hash;
  logic         h_done;

  modport master (
    output h_start, h_data, h_rdy,
    input  h_rq, h_addr, h_hash, h_done
  );

  modport slave (
    input  h_start, h_data, h_rdy,
    output h_rq, h_addr, h_hash, h_done
  );
endinterface

// File: rtl/nonce_sweeper.sv
// rtl/nonce_sweeper.sv - header word server and leading-zero nonce search controller
module nonce_sweeper #(
  parameter int SWEEP_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ld_valid,
  input  logic [4:0]           ld_addr,
  input  logic [31:0]          ld_data,
  input  logic [7:0]           zeros,
  input  logic                 start,
  nonce_sweeper_if.master      hsh,
  output logic                 busy,
  output logic                 found,
  output logic                 exhausted,
  output logic [31:0]          nonce
);

  typedef enum logic [1:0] {IDLE, LAUNCH, HASH, CHECK} state_t;

  state_t                state, state_n;
  logic [31:0]           hdr [0:19];
  logic [7:0]            zeros_q;
  logic [SWEEP_BITS-1:0] cnt;
  logic                  rq_d;
  logic                  pass_q;
  logic                  rdy_q;
  logic [31:0]           data_q;
  logic                  rq_edge;
  logic                  last_try;

  // Hash bytes arrive byte 0 first; the target compares them as a little-endian number.
  function automatic logic hash_pass(input logic [255:0] h, input logic [7:0] z);
    logic [255:0] v;
    logic [255:0] mask;
    for (int i = 0; i < 32; i++) v[8*i +: 8] = h[255-8*i -: 8];
    mask = ~({256{1'b1}} >> z);
    return (v & mask) == '0;
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign rq_edge  = hsh.h_rq && !rq_d;
  assign last_try = &cnt;
  assign busy     = (state != IDLE);
  assign hsh.h_start = (state == LAUNCH);
  assign hsh.h_rdy   = rdy_q;
  assign hsh.h_data  = data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (start) state_n = LAUNCH;
      LAUNCH: state_n = HASH;
      HASH:   if (hsh.h_done) state_n = CHECK;
      CHECK:  state_n = (pass_q || last_try) ? IDLE : LAUNCH;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 20; i++) hdr[i] <= '0;
      zeros_q   <= '0;
      cnt       <= '0;
      nonce     <= '0;
      found     <= 1'b0;
      exhausted <= 1'b0;
      rq_d      <= 1'b0;
      pass_q    <= 1'b0;
      rdy_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      rq_d  <= (state == LAUNCH) ? 1'b0 : hsh.h_rq;
      rdy_q <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_valid && ld_addr < 5'd20) hdr[ld_addr] <= ld_data;
          if (start) begin
            zeros_q   <= zeros;
            nonce     <= bswap(hdr[19]);
            cnt       <= '0;
            found     <= 1'b0;
            exhausted <= 1'b0;
          end
        end
        HASH: begin
          // A result ends the hash, so a request edge on the same cycle is dropped.
          if (hsh.h_done) begin
            pass_q <= hash_pass(hsh.h_hash, zeros_q);
          end else if (rq_edge) begin
            rdy_q <= 1'b1;
            if (hsh.h_addr == 5'd19)     data_q <= bswap(nonce);
            else if (hsh.h_addr < 5'd19) data_q <= hdr[hsh.h_addr];
            else                         data_q <= '0;
          end
        end
        CHECK: begin
          if (pass_q) begin
            found <= 1'b1;
          end else if (last_try) begin
            exhausted <= 1'b1;
          end else begin
            nonce <= nonce + 32'd1;
            cnt   <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_sweeper.sv
// tb/tb_nonce_sweeper.sv - directed bench for nonce_sweeper with SWEEP_BITS = 2
module tb_nonce_sweeper;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_valid = 1'b0;
  logic [4:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [7:0]  zeros = '0;
  logic        start = 1'b0;
  logic        busy, found, exhausted;
  logic [31:0] nonce;
  int          n_assert = 0;
  int          n_fail = 0;
  int          hs_cnt = 0;
  int          hs_base;
  logic [255:0] genesis_raw;
  logic [31:0]  exp_n [4];

  nonce_sweeper_if hif ();

  nonce_sweeper #(.SWEEP_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_data(ld_data), .zeros(zeros), .start(start), .hsh(hif),
    .busy(busy), .found(found), .exhausted(exhausted), .nonce(nonce)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (hif.h_start) hs_cnt++;

  function automatic logic [255:0] brev(input logic [255:0] x);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255-8*i -: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ld(input logic [4:0] a, input logic [31:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic go(input logic [7:0] z);
    zeros = z; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic req(input string tag, input logic [4:0] a, input logic [31:0] exp);
    hif.h_addr = a; hif.h_rq = 1'b1;
    tick();
    chk({tag, "_rdy"}, {31'd0, hif.h_rdy}, 32'd1);
    chk({tag, "_data"}, hif.h_data, exp);
    tick();
    chk({tag, "_rdy_hold"}, {31'd0, hif.h_rdy}, 32'd0);
    chk({tag, "_data_hold"}, hif.h_data, exp);
    hif.h_rq = 1'b0;
    tick();
  endtask

  task automatic hash(input logic [255:0] raw);
    hif.h_hash = raw; hif.h_done = 1'b1;
    tick();
    hif.h_done = 1'b0;
  endtask

  task automatic wait_hstart(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (hif.h_start) break;
      tick();
    end
    chk(tag, {31'd0, hif.h_start}, 32'd1);
  endtask

  initial begin
    hif.h_rq = 1'b0; hif.h_addr = '0; hif.h_hash = '0; hif.h_done = 1'b0;
    genesis_raw = brev(256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f);
    exp_n = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};

    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_h_start", {31'd0, hif.h_start}, 32'd0);
    chk("rst_h_rdy", {31'd0, hif.h_rdy}, 32'd0);
    chk("rst_h_data", hif.h_data, 32'd0);
    chk("rst_found", {31'd0, found}, 32'd0);
    chk("rst_exhausted", {31'd0, exhausted}, 32'd0);
    chk("rst_nonce", nonce, 32'd0);
    rst_n = 1'b1;
    tick();

    // Genesis-style sweep: 43 leading zero bits against a 32-bit target.
    for (int i = 0; i < 19; i++) ld(5'(i), 32'hA5000000 | 32'(i));
    ld(5'd19, 32'h1DAC2B7C);
    hs_base = hs_cnt;
    go(8'd32);
    chk("gen_busy", {31'd0, busy}, 32'd1);
    chk("gen_h_start", {31'd0, hif.h_start}, 32'd1);
    chk("gen_nonce_base", nonce, 32'h7C2BAC1D);
    tick();
    chk("gen_h_start_pulse", {31'd0, hif.h_start}, 32'd0);
    req("gen_w19", 5'd19, 32'h1DAC2B7C);
    hash(genesis_raw);
    chk("gen_check_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("gen_found", {31'd0, found}, 32'd1);
    chk("gen_exhausted", {31'd0, exhausted}, 32'd0);
    chk("gen_busy_fall", {31'd0, busy}, 32'd0);
    chk("gen_nonce", nonce, 32'h7C2BAC1D);
    chk("gen_hstarts", 32'(hs_cnt - hs_base), 32'd1);

    // 44-bit target misses the genesis hash, then an all-zero hash hits on base+1.
    go(8'd44);
    chk("z44_found_clr", {31'd0, found}, 32'd0);
    tick();
    hash(genesis_raw);
    tick();
    chk("z44_relaunch", {31'd0, hif.h_start}, 32'd1);
    chk("z44_nonce_inc", nonce, 32'h7C2BAC1E);
    tick();
    hash('0);
    tick();
    chk("z44_found", {31'd0, found}, 32'd1);
    chk("z44_nonce", nonce, 32'h7C2BAC1E);

    // Word serving, zeros = 0, ignored mid-sweep writes and starts.
    ld(5'd3, 32'hDEADBEEF);
    ld(5'd19, 32'h78563412);
    go(8'd0);
    chk("srv_nonce_base", nonce, 32'h12345678);
    tick();
    req("srv_w3", 5'd3, 32'hDEADBEEF);
    req("srv_w19", 5'd19, 32'h78563412);
    req("srv_w25", 5'd25, 32'h00000000);
    ld_valid = 1'b1; ld_addr = 5'd0; ld_data = 32'hFFFFFFFF; start = 1'b1;
    tick();
    ld_valid = 1'b0; start = 1'b0;
    chk("srv_ign_busy", {31'd0, busy}, 32'd1);
    chk("srv_ign_h_start", {31'd0, hif.h_start}, 32'd0);
    hif.h_rq = 1'b1; hif.h_addr = 5'd0;
    hash('1);
    hif.h_rq = 1'b0;
    chk("srv_done_wins_rdy", {31'd0, hif.h_rdy}, 32'd0);
    tick();
    chk("srv_z0_found", {31'd0, found}, 32'd1);
    chk("srv_z0_nonce", nonce, 32'h12345678);
    go(8'd0);
    tick();
    req("srv_w0_kept", 5'd0, 32'hA5000000);
    hash('1);
    tick();

    // Four-nonce window wrapping through zero.
    ld(5'd19, 32'hFEFFFFFF);
    hs_base = hs_cnt;
    go(8'd255);
    for (int k = 0; k < 4; k++) begin
      wait_hstart("exh_h_start");
      chk("exh_nonce_step", nonce, exp_n[k]);
      tick();
      hash('1);
    end
    tick();
    chk("exh_exhausted", {31'd0, exhausted}, 32'd1);
    chk("exh_found", {31'd0, found}, 32'd0);
    chk("exh_busy", {31'd0, busy}, 32'd0);
    chk("exh_nonce", nonce, 32'h00000001);
    chk("exh_hstarts", 32'(hs_cnt - hs_base), 32'd4);

    // Reset during HASH wipes everything, including the header.
    go(8'd255);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_h_start", {31'd0, hif.h_start}, 32'd0);
    chk("mrst_h_rdy", {31'd0, hif.h_rdy}, 32'd0);
    chk("mrst_found", {31'd0, found}, 32'd0);
    chk("mrst_exhausted", {31'd0, exhausted}, 32'd0);
    chk("mrst_nonce", nonce, 32'd0);
    go(8'd0);
    chk("mrst_h_start_new", {31'd0, hif.h_start}, 32'd1);
    tick();
    req("mrst_w5", 5'd5, 32'h00000000);
    hash('1);
    tick();
    chk("mrst_found_new", {31'd0, found}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
